// File: rtl/cep_backdoor_pkg.sv
// Shared types for the scratchpad backdoor responder.
// Backdoor request/response bundles and FSM state encoding.
package cep_backdoor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        RD_WAIT,
        RESP
    } bd_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
    } bd_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } bd_rsp_t;

    localparam int BD_BYTE_OFFSET = 3;

endpackage

// File: rtl/scratchpad_backdoor_responder.sv
// Backdoor valid/ready access path into the scratchpad SRAM, arbitrated
// against the primary port with bounded starvation for the backdoor.
module scratchpad_backdoor_responder
    import cep_backdoor_pkg::*;
#(
    parameter int MEM_DEPTH    = 65536,
    parameter int MEM_AW       = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              bd_req_valid,
    output logic              bd_req_ready,
    input  logic              bd_req_write,
    input  logic [31:0]       bd_req_addr,
    input  logic [63:0]       bd_req_wdata,
    input  logic [7:0]        bd_req_mask,
    output logic              bd_rsp_valid,
    input  logic              bd_rsp_ready,
    output logic [63:0]       bd_rsp_rdata,
    output logic              bd_rsp_err,

    input  logic              pri_valid,
    input  logic              pri_write,
    input  logic [MEM_AW-1:0] pri_addr,
    input  logic [63:0]       pri_wdata,
    input  logic [7:0]        pri_mask,
    output logic              pri_ready,
    output logic [63:0]       pri_rdata,

    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_mask,
    input  logic [63:0]       mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    bd_state_e     state, state_nx;
    bd_req_t       req_q;
    bd_rsp_t       rsp_q, rsp_nx;
    logic [SW-1:0] starve_cnt, starve_nx;
    logic          bd_win;
    logic          addr_err;

    assign addr_err = (req_q.addr[BD_BYTE_OFFSET-1:0] != '0)
                   || ((req_q.addr >> BD_BYTE_OFFSET) >= 32'(MEM_DEPTH));

    assign bd_win = (state == ISSUE)
                 && (!pri_valid || starve_cnt == SW'(STARVE_LIMIT));

    always_comb begin
        state_nx  = state;
        rsp_nx    = rsp_q;
        starve_nx = starve_cnt;
        unique case (state)
            IDLE: begin
                if (bd_req_valid) state_nx = CHECK;
            end
            CHECK: begin
                if (addr_err) begin
                    rsp_nx.err   = 1'b1;
                    rsp_nx.rdata = '0;
                    state_nx     = RESP;
                end else begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (bd_win) begin
                    starve_nx = '0;
                    state_nx  = req_q.write ? RESP : RD_WAIT;
                end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                    starve_nx = starve_cnt + 1'b1;
                end
            end
            RD_WAIT: begin
                rsp_nx.rdata = mem_rdata;
                state_nx     = RESP;
            end
            RESP: begin
                if (bd_rsp_ready) begin
                    rsp_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rsp_q      <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            rsp_q      <= rsp_nx;
            starve_cnt <= starve_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (bd_req_valid && bd_req_ready) begin
            req_q.write <= bd_req_write;
            req_q.addr  <= bd_req_addr;
            req_q.wdata <= bd_req_wdata;
            req_q.mask  <= bd_req_mask;
        end
    end

    assign bd_req_ready = !rst && (state == IDLE);
    assign bd_rsp_valid = !rst && (state == RESP);
    assign bd_rsp_rdata = rsp_q.rdata;
    assign bd_rsp_err   = rsp_q.err;

    assign pri_ready = !rst && !bd_win;
    assign pri_rdata = mem_rdata;

    // The write strobe is masked by rst so an in-flight ISSUE never lands.
    always_comb begin
        if (bd_win) begin
            mem_addr  = req_q.addr[MEM_AW+BD_BYTE_OFFSET-1:BD_BYTE_OFFSET];
            mem_wdata = req_q.wdata;
            mem_mask  = req_q.mask;
            mem_write = req_q.write && !rst;
        end else begin
            mem_addr  = pri_addr;
            mem_wdata = pri_wdata;
            mem_mask  = pri_mask;
            mem_write = pri_valid && pri_write && !rst;
        end
    end

endmodule

// File: tb/tb_scratchpad_backdoor_responder.sv
// Bench for scratchpad_backdoor_responder: directed cases with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_scratchpad_backdoor_responder;

    localparam int MEM_DEPTH    = 65536;
    localparam int MEM_AW       = 16;
    localparam int STARVE_LIMIT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bd_req_valid = 1'b0;
    logic              bd_req_ready;
    logic              bd_req_write = 1'b0;
    logic [31:0]       bd_req_addr = '0;
    logic [63:0]       bd_req_wdata = '0;
    logic [7:0]        bd_req_mask = '0;
    logic              bd_rsp_valid;
    logic              bd_rsp_ready = 1'b0;
    logic [63:0]       bd_rsp_rdata;
    logic              bd_rsp_err;
    logic              pri_valid = 1'b0;
    logic              pri_write = 1'b0;
    logic [MEM_AW-1:0] pri_addr = '0;
    logic [63:0]       pri_wdata = '0;
    logic [7:0]        pri_mask = '0;
    logic              pri_ready;
    logic [63:0]       pri_rdata;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [7:0]        mem_mask;
    logic [63:0]       mem_rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scratchpad_backdoor_responder #(
        .MEM_DEPTH(MEM_DEPTH),
        .MEM_AW(MEM_AW),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .bd_req_valid(bd_req_valid), .bd_req_ready(bd_req_ready),
        .bd_req_write(bd_req_write), .bd_req_addr(bd_req_addr),
        .bd_req_wdata(bd_req_wdata), .bd_req_mask(bd_req_mask),
        .bd_rsp_valid(bd_rsp_valid), .bd_rsp_ready(bd_rsp_ready),
        .bd_rsp_rdata(bd_rsp_rdata), .bd_rsp_err(bd_rsp_err),
        .pri_valid(pri_valid), .pri_write(pri_write), .pri_addr(pri_addr),
        .pri_wdata(pri_wdata), .pri_mask(pri_mask),
        .pri_ready(pri_ready), .pri_rdata(pri_rdata),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .mem_rdata(mem_rdata)
    );

    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] nw,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++)
            if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] init_val(input int i);
        return {32'(i) ^ 32'hA5A5_0000, 32'(i) * 32'h9E37_79B9};
    endfunction

    task automatic report(input string nm, input string act, input string exp);
        errors++;
        if (errors <= 40)
            $display("FAIL %s: got %s, expected %s (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) report(nm, $sformatf("%b", act), $sformatf("%b", exp));
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) report(nm, $sformatf("%h", act), $sformatf("%h", exp));
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) report(nm, $sformatf("%0d", act), $sformatf("%0d", exp));
    endtask

    // SRAM: registered read (read-first), byte-masked write.
    logic [63:0] sram [MEM_DEPTH];
    bit sram_init = 0;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < MEM_DEPTH; i++) sram[i] = init_val(i);
            sram_init = 1;
        end
        mem_rdata <= sram[mem_addr];
        if (mem_write) sram[mem_addr] = merge(sram[mem_addr], mem_wdata, mem_mask);
    end

    // Reference model: a pending backdoor transaction is tracked by its age in
    // cycles since acceptance; ISSUE begins at age 2 and the backdoor wins at
    // the first idle-primary cycle or after STARVE_LIMIT lost cycles.
    logic [63:0]       ref_mem [MEM_DEPTH];
    bit                ref_init = 0;
    bit                m_busy = 0, m_resp = 0, m_won = 0, m_err = 0, m_w = 0;
    int                m_age = 0, m_won_age = 0;
    logic [MEM_AW-1:0] m_word = '0;
    logic [63:0]       m_d = '0, m_rdata = '0;
    logic [7:0]        m_m = '0;
    bit                exp_prd_v = 0;
    logic [63:0]       exp_prd = '0;
    int                mw_cnt = 0, stall_cnt = 0, rv_cnt = 0, rdy_cnt = 0;
    logic [MEM_AW-1:0] mw_last_addr = '0;

    always @(negedge clk) begin : model
        bit win;
        if (!ref_init) begin
            for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = init_val(i);
            ref_init = 1;
        end
        if (mem_write) begin
            mw_cnt++;
            mw_last_addr = mem_addr;
        end
        if (pri_valid && !pri_ready && !rst) stall_cnt++;
        if (bd_rsp_valid) rv_cnt++;
        if (bd_req_ready) rdy_cnt++;

        if (rst) begin
            chk1("rst_req_ready", bd_req_ready, 1'b0);
            chk1("rst_rsp_valid", bd_rsp_valid, 1'b0);
            chk1("rst_pri_ready", pri_ready, 1'b0);
            chk1("rst_mem_write", mem_write, 1'b0);
            m_busy = 0;
            m_resp = 0;
            exp_prd_v = 0;
        end else begin
            win = 0;
            if (m_busy && !m_resp && !m_err && !m_won && m_age >= 2)
                win = !pri_valid || (m_age - 2 == STARVE_LIMIT);

            chk1("req_ready", bd_req_ready, !m_busy);
            chk1("rsp_valid", bd_rsp_valid, m_resp);
            chk64("rsp_rdata", bd_rsp_rdata, m_resp ? m_rdata : 64'd0);
            chk1("rsp_err", bd_rsp_err, m_resp ? m_err : 1'b0);
            chk1("pri_ready", pri_ready, !win);
            if (exp_prd_v) chk64("pri_rdata", pri_rdata, exp_prd);
            if (win) begin
                chk1("bd_mem_write", mem_write, m_w);
                chk64("bd_mem_addr", 64'(mem_addr), 64'(m_word));
                if (m_w) begin
                    chk64("bd_mem_wdata", mem_wdata, m_d);
                    chk64("bd_mem_mask", 64'(mem_mask), 64'(m_m));
                end
            end else begin
                chk1("pri_mem_write", mem_write, pri_valid && pri_write);
                if (pri_valid) chk64("pri_mem_addr", 64'(mem_addr), 64'(pri_addr));
                if (pri_valid && pri_write) begin
                    chk64("pri_mem_wdata", mem_wdata, pri_wdata);
                    chk64("pri_mem_mask", 64'(mem_mask), 64'(pri_mask));
                end
            end

            exp_prd_v = 0;
            if (!win && pri_valid) begin
                if (pri_write) begin
                    ref_mem[pri_addr] = merge(ref_mem[pri_addr], pri_wdata, pri_mask);
                end else begin
                    exp_prd_v = 1;
                    exp_prd = ref_mem[pri_addr];
                end
            end
            if (win) begin
                if (m_w) ref_mem[m_word] = merge(ref_mem[m_word], m_d, m_m);
                else m_rdata = ref_mem[m_word];
                m_won = 1;
                m_won_age = m_age;
            end

            if (m_resp) begin
                if (bd_rsp_ready) begin
                    m_busy = 0;
                    m_resp = 0;
                end
            end else if (m_busy) begin
                m_age++;
                if (m_err && m_age == 2) m_resp = 1;
                else if (m_won && m_age == m_won_age + (m_w ? 1 : 2)) m_resp = 1;
            end else if (bd_req_valid) begin
                m_busy = 1;
                m_age = 1;
                m_won = 0;
                m_w = bd_req_write;
                m_d = bd_req_wdata;
                m_m = bd_req_mask;
                m_word = MEM_AW'(bd_req_addr >> 3);
                m_err = (bd_req_addr[2:0] != 3'd0) || ((bd_req_addr >> 3) >= 32'(MEM_DEPTH));
                m_rdata = '0;
            end
        end
    end

    // One backdoor transaction; starts and ends just after a rising edge.
    task automatic bd_go(input logic w, input logic [31:0] a, input logic [63:0] d,
                         input logic [7:0] m, input int hold, input bit keep,
                         output logic [63:0] rd, output logic er, output int lat,
                         output int mw, output int stall, output int rdy);
        int k, n, mw0, st0, rdy0;
        bit ok;
        mw0 = mw_cnt;
        st0 = stall_cnt;
        rd = '0;
        er = 1'b0;
        lat = -1;
        rdy = 0;
        ok = 1;
        bd_req_write = w;
        bd_req_addr = a;
        bd_req_wdata = d;
        bd_req_mask = m;
        bd_req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bd_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bd_req_ready) begin
            chk1("bd_req_accept_timeout", bd_req_ready, 1'b1);
            ok = 0;
        end
        k = cyc;
        @(posedge clk);
        #1;
        if (!keep || !ok) bd_req_valid = 1'b0;
        rdy0 = rdy_cnt;
        if (ok) begin
            n = 0;
            @(negedge clk);
            while (!bd_rsp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!bd_rsp_valid) chk1("bd_rsp_timeout", bd_rsp_valid, 1'b1);
            lat = cyc - k;
            rd = bd_rsp_rdata;
            er = bd_rsp_err;
            repeat (hold) @(posedge clk);
            @(posedge clk);
            #1 bd_rsp_ready = 1'b1;
            @(posedge clk);
            #1 bd_rsp_ready = 1'b0;
        end
        rdy = rdy_cnt - rdy0;
        mw = mw_cnt - mw0;
        stall = stall_cnt - st0;
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat, mw, st, rdy, mw0, rv0;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("reset_req_ready", bd_req_ready, 1'b1);
        chk1("reset_rsp_valid", bd_rsp_valid, 1'b0);
        chk64("reset_rsp_rdata", bd_rsp_rdata, 64'd0);
        chk1("reset_pri_ready", pri_ready, 1'b1);
        @(posedge clk);
        #1;

        bd_go(1'b1, 32'h100, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0, rd, er, lat, mw, st, rdy);
        chk1("wr100_err", er, 1'b0);
        chk_int("wr100_latency", lat, 3);
        chk_int("wr100_mem_write_cycles", mw, 1);
        chk_int("wr100_mem_addr", int'(mw_last_addr), 32'h20);

        bd_go(1'b0, 32'h100, 64'd0, 8'h00, 0, 0, rd, er, lat, mw, st, rdy);
        chk64("rd100_data", rd, 64'hDEADBEEF_CAFEF00D);
        chk1("rd100_err", er, 1'b0);
        chk_int("rd100_latency", lat, 4);
        chk_int("rd100_mem_write_cycles", mw, 0);

        bd_go(1'b0, 32'h104, 64'd0, 8'h00, 0, 0, rd, er, lat, mw, st, rdy);
        chk1("misaligned_err", er, 1'b1);
        chk64("misaligned_rdata", rd, 64'd0);
        chk_int("misaligned_latency", lat, 2);

        bd_go(1'b1, 32'h0008_0000, 64'h5555_AAAA_5555_AAAA, 8'hFF, 0, 0,
              rd, er, lat, mw, st, rdy);
        chk1("oor_err", er, 1'b1);
        chk64("oor_rdata", rd, 64'd0);
        chk_int("oor_mem_write_cycles", mw, 0);

        pri_valid = 1'b1;
        pri_write = 1'b0;
        pri_addr = 16'h0010;
        bd_go(1'b1, 32'h200, 64'h0F0F_1234_5678_F0F0, 8'hFF, 0, 0,
              rd, er, lat, mw, st, rdy);
        pri_valid = 1'b0;
        chk_int("starve_latency", lat, 3 + STARVE_LIMIT);
        chk_int("starve_pri_stall_cycles", st, 1);
        chk_int("starve_mem_write_cycles", mw, 1);

        bd_go(1'b0, 32'h100, 64'd0, 8'h00, 20, 1, rd, er, lat, mw, st, rdy);
        chk64("hold_rdata", rd, 64'hDEADBEEF_CAFEF00D);
        chk_int("hold_req_ready_cycles", rdy, 0);
        bd_go(1'b0, 32'h200, 64'd0, 8'h00, 0, 0, rd, er, lat, mw, st, rdy);
        chk64("after_hold_rdata", rd, 64'h0F0F_1234_5678_F0F0);
        chk_int("after_hold_latency", lat, 4);

        mw0 = mw_cnt;
        rv0 = rv_cnt;
        pri_valid = 1'b1;
        bd_req_write = 1'b1;
        bd_req_addr = 32'h1000;
        bd_req_wdata = 64'h1111_1111_1111_1111;
        bd_req_mask = 8'hFF;
        bd_req_valid = 1'b1;
        @(posedge clk);
        #1 bd_req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        pri_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("post_rst_req_ready", bd_req_ready, 1'b1);
        chk1("post_rst_rsp_valid", bd_rsp_valid, 1'b0);
        chk1("post_rst_rsp_err", bd_rsp_err, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk_int("rst_issue_mem_writes", mw_cnt - mw0, 0);
        chk_int("rst_issue_responses", rv_cnt - rv0, 0);
        bd_go(1'b0, 32'h1000, 64'd0, 8'h00, 0, 0, rd, er, lat, mw, st, rdy);
        chk64("rst_issue_word_unchanged", rd, init_val(32'h200));

        fork
            begin
                for (int j = 0; j < 24; j++) begin
                    pri_valid = 1'($urandom_range(0, 1));
                    pri_write = 1'b0;
                    pri_addr = 16'h0010;
                    @(posedge clk);
                    #1;
                end
                pri_valid = 1'b0;
            end
            bd_go(1'b1, 32'h80, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 0,
                  rd, er, lat, mw, st, rdy);
        join
        chk1("interleave_stall_le1", st <= 1, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            int pct;
            int r;
            logic [31:0] a;
            pct = ((i / 500) % 2 == 1) ? 95 : 40;
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 31)) << 3;
            if (r == 0) a = a | 32'($urandom_range(1, 7));
            else if (r == 1) a = $urandom_range(32'hFFFF_FFFF, 32'h0008_0000);
            rst = ($urandom_range(0, 399) == 0);
            bd_req_valid = ($urandom_range(0, 2) == 0);
            bd_req_write = 1'($urandom_range(0, 1));
            bd_req_addr = a;
            bd_req_wdata = {$urandom, $urandom};
            bd_req_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            bd_rsp_ready = 1'($urandom_range(0, 1));
            pri_valid = ($urandom_range(0, 99) < pct);
            pri_write = ($urandom_range(0, 9) < 3);
            pri_addr = MEM_AW'($urandom_range(0, 31));
            pri_wdata = {$urandom, $urandom};
            pri_mask = 8'($urandom);
            @(posedge clk);
            #1;
        end

        rst = 1'b0;
        bd_req_valid = 1'b0;
        pri_valid = 1'b0;
        bd_rsp_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
